// File: rtl/updn_counter.sv
// Up/down counter driven by two active-low push buttons with press
// detection, hold-to-auto-repeat, wrap or saturate at the limits, a
// one-cycle limit pulse and a 7-segment hex glyph of the low nibble.
module updn_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int SAT      = 0,
    parameter int HOLD_CYC = 8,
    parameter int RPT_CYC  = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [1:0]       i_Push,
    output logic [WIDTH-1:0] o_LED,
    output logic [6:0]       o_FND,
    output logic             o_Lim
);

    // Timer only ever holds 0 .. HOLD_CYC+RPT_CYC-1: once the repeat phase
    // starts it folds back to HOLD_CYC, so it can never overflow.
    localparam int               TW     = $clog2(HOLD_CYC + RPT_CYC);
    localparam logic [TW-1:0]    HOLD_T = TW'(HOLD_CYC);
    localparam logic [TW-1:0]    LAST_T = TW'(HOLD_CYC + RPT_CYC - 1);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [1:0]       prev_reg;
    logic [1:0]       step;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             lim_reg;
    logic             lim_next;
    logic [3:0]       nib;

    // Previous button sample; reset to "released" so a button held through
    // reset release is seen as a fresh press.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) prev_reg <= 2'b11;
        else        prev_reg <= i_Push;
    end

    // Per-button press / hold / repeat logic (bit1 = up, bit0 = down).
    // A button only steps while the other button is released: with both low
    // nothing steps, timers clear and repeats stay off until a new press.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [TW-1:0] t_reg;
            logic [TW-1:0] t_next;
            logic          arm_reg;
            logic          arm_next;
            logic          step_b;
            logic          low;
            logic          other_low;
            logic          press;

            assign low       = ~i_Push[gi];
            assign other_low = ~i_Push[1-gi];
            assign press     = low & prev_reg[gi];
            assign step[gi]  = step_b;

            // Next timer/arm state and this button's step request.
            always_comb begin
                t_next   = t_reg;
                arm_next = arm_reg;
                step_b   = 1'b0;
                if (!low || other_low) begin
                    t_next   = '0;
                    arm_next = 1'b0;
                end else if (press) begin
                    // t is 0 in the press cycle, so the next cycle sees 1
                    t_next   = TW'(1);
                    arm_next = 1'b1;
                    step_b   = 1'b1;
                end else if (arm_reg) begin
                    step_b = (t_reg == HOLD_T);
                    t_next = (t_reg == LAST_T) ? HOLD_T : t_reg + TW'(1);
                end
            end

            // Timer and arm registers.
            always_ff @(posedge i_Clk) begin
                if (!i_Rst) begin
                    t_reg   <= '0;
                    arm_reg <= 1'b0;
                end else begin
                    t_reg   <= t_next;
                    arm_reg <= arm_next;
                end
            end
        end
    endgenerate

    // Count arithmetic with wrap or saturate at 0 / MAX_VAL; opposite
    // simultaneous steps cancel out.
    always_comb begin
        count_next = count_reg;
        lim_next   = 1'b0;
        if (step == 2'b10) begin
            if (count_reg == MAX_C) begin
                lim_next   = 1'b1;
                count_next = (SAT != 0) ? MAX_C : '0;
            end else begin
                count_next = count_reg + ONE;
            end
        end else if (step == 2'b01) begin
            if (count_reg == '0) begin
                lim_next   = 1'b1;
                count_next = (SAT != 0) ? '0 : MAX_C;
            end else begin
                count_next = count_reg - ONE;
            end
        end
    end

    // Count and limit-pulse registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            count_reg <= '0;
            lim_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            lim_reg   <= lim_next;
        end
    end

    // Low nibble of the count, zero-extended for narrow counters.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            if (gi < WIDTH) begin : g_bit
                assign nib[gi] = count_reg[gi];
            end else begin : g_zero
                assign nib[gi] = 1'b0;
            end
        end
    endgenerate

    // Hex glyph decode, segments active-high, bit0 = a .. bit6 = g.
    always_comb begin
        o_FND = 7'h00;
        case (nib)
            4'h0: o_FND = 7'h3F;
            4'h1: o_FND = 7'h06;
            4'h2: o_FND = 7'h5B;
            4'h3: o_FND = 7'h4F;
            4'h4: o_FND = 7'h66;
            4'h5: o_FND = 7'h6D;
            4'h6: o_FND = 7'h7D;
            4'h7: o_FND = 7'h07;
            4'h8: o_FND = 7'h7F;
            4'h9: o_FND = 7'h6F;
            4'hA: o_FND = 7'h77;
            4'hB: o_FND = 7'h7C;
            4'hC: o_FND = 7'h39;
            4'hD: o_FND = 7'h5E;
            4'hE: o_FND = 7'h79;
            4'hF: o_FND = 7'h71;
            default: o_FND = 7'h00;
        endcase
    end

    assign o_LED = count_reg;
    assign o_Lim = lim_reg;

endmodule

// File: tb/tb_updn_counter.sv
// Bench for updn_counter: a wrap instance and a saturate instance share one
// stimulus stream; a behavioural model predicts both every cycle, and a few
// directed scenarios pin the model with hand-computed values.
module tb_updn_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int HOLD = 8;
    localparam int RPT  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   push;
    logic [W-1:0] led0, led1;
    logic [6:0]   fnd0, fnd1;
    logic         lim0, lim1;

    updn_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SAT(0), .HOLD_CYC(HOLD), .RPT_CYC(RPT)) u_wrap (
        .i_Clk(clk), .i_Rst(rst_n), .i_Push(push),
        .o_LED(led0), .o_FND(fnd0), .o_Lim(lim0)
    );

    updn_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SAT(1), .HOLD_CYC(HOLD), .RPT_CYC(RPT)) u_sat (
        .i_Clk(clk), .i_Rst(rst_n), .i_Push(push),
        .o_LED(led1), .o_FND(fnd1), .o_Lim(lim1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t is the number of cycles since the press (unbounded); a repeat is
    // due whenever m_t >= HOLD and (m_t - HOLD) is a multiple of RPT.
    int       m_cnt [2];
    bit       m_lim [2];
    bit [1:0] m_prev;
    int       m_t   [2];
    bit       m_arm [2];
    bit       model_ok = 1'b0;

    always @(posedge clk) begin
        bit stp [2];
        bit low, other_low, up, dn;
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_cnt[s] = 0; m_lim[s] = 0; m_t[s] = 0; m_arm[s] = 0;
            end
            m_prev   = 2'b11;
            model_ok = 1'b1;
        end else begin
            for (int b = 0; b < 2; b++) begin
                low       = !push[b];
                other_low = !push[1-b];
                stp[b]    = 1'b0;
                if (!low || other_low) begin
                    m_arm[b] = 0; m_t[b] = 0;
                end else if (m_prev[b]) begin
                    stp[b] = 1'b1; m_arm[b] = 1; m_t[b] = 0;
                end else if (m_arm[b]) begin
                    m_t[b] = m_t[b] + 1;
                    stp[b] = (m_t[b] >= HOLD) && (((m_t[b] - HOLD) % RPT) == 0);
                end
            end
            m_prev = push;
            up = stp[1] && !stp[0];
            dn = stp[0] && !stp[1];
            for (int s = 0; s < 2; s++) begin
                m_lim[s] = 0;
                if (up) begin
                    if (m_cnt[s] == MAXV) begin m_lim[s] = 1; m_cnt[s] = (s == 1) ? MAXV : 0; end
                    else m_cnt[s] = m_cnt[s] + 1;
                end else if (dn) begin
                    if (m_cnt[s] == 0) begin m_lim[s] = 1; m_cnt[s] = (s == 1) ? 0 : MAXV; end
                    else m_cnt[s] = m_cnt[s] - 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("cyc_led_wrap", int'(led0), m_cnt[0]);
            chk("cyc_fnd_wrap", int'(fnd0), int'(glyph[m_cnt[0]]));
            chk("cyc_lim_wrap", int'(lim0), int'(m_lim[0]));
            chk("cyc_led_sat",  int'(led1), m_cnt[1]);
            chk("cyc_fnd_sat",  int'(fnd1), int'(glyph[m_cnt[1]]));
            chk("cyc_lim_sat",  int'(lim1), int'(m_lim[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push encodings (active-low, bit1 = up, bit0 = down)
    localparam logic [1:0] P_NONE = 2'b11;
    localparam logic [1:0] P_UP   = 2'b01;
    localparam logic [1:0] P_DN   = 2'b10;
    localparam logic [1:0] P_BOTH = 2'b00;

    // ---------------- stimulus ----------------
    initial begin
        int r, n;
        rst_n = 1'b0;
        push  = P_BOTH;

        // Reset with both buttons low
        tick(2);
        chk("rst_led",  int'(led0), 0);
        chk("rst_fnd",  int'(fnd0), 'h3F);
        chk("rst_lim",  int'(lim0), 0);
        chk("rst_led_sat", int'(led1), 0);
        rst_n = 1'b1;
        tick(1);
        chk("rel_both_led", int'(led0), 0);
        chk("rel_both_lim", int'(lim0), 0);
        push = P_NONE;
        tick(2);

        // Three single up presses, then one down press
        for (int k = 1; k <= 3; k++) begin
            push = P_UP;
            chk("pre_edge_led", int'(led0), k - 1);
            tick(1);
            chk("up_press_led", int'(led0), k);
            push = P_NONE;
            tick(1);
        end
        push = P_DN;
        tick(1);
        chk("dn_press_led", int'(led0), 2);
        chk("dn_press_fnd", int'(fnd0), 'h5B);
        push = P_NONE;
        tick(1);

        // Climb to 9, then wrap vs saturate
        repeat (7) begin
            push = P_UP;   tick(1);
            push = P_NONE; tick(1);
        end
        chk("at_max_wrap", int'(led0), 9);
        chk("at_max_sat",  int'(led1), 9);
        push = P_UP; tick(1);
        chk("wrap_up_led", int'(led0), 0);
        chk("wrap_up_lim", int'(lim0), 1);
        chk("sat_up_led",  int'(led1), 9);
        chk("sat_up_lim",  int'(lim1), 1);
        push = P_NONE; tick(1);
        chk("wrap_lim_off", int'(lim0), 0);
        chk("sat_lim_off",  int'(lim1), 0);
        push = P_DN; tick(1);
        chk("wrap_dn_led", int'(led0), 9);
        chk("wrap_dn_lim", int'(lim0), 1);
        chk("sat_dn_led",  int'(led1), 8);
        chk("sat_dn_lim",  int'(lim1), 0);
        push = P_NONE; tick(1);

        // Auto-repeat: up held 20 cycles from 0 -> steps at t=0,8,12,16
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(1);
        push = P_UP;
        tick(8);
        chk("rpt_before_hold", int'(led0), 1);
        tick(1);
        chk("rpt_at_hold", int'(led0), 2);
        tick(11);
        chk("rpt_final", int'(led0), 4);
        push = P_NONE; tick(1);
        push = P_DN;   tick(7);
        chk("short_hold_dn", int'(led0), 3);
        push = P_NONE; tick(1);

        // Saturate at 0 on a down press
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(1);
        push = P_DN; tick(1);
        chk("zero_dn_wrap_led", int'(led0), 9);
        chk("zero_dn_sat_led",  int'(led1), 0);
        chk("zero_dn_sat_lim",  int'(lim1), 1);
        push = P_NONE; tick(1);

        // Up held, down joins at t=5, reset at t=10
        push = P_UP;   tick(5);
        chk("mid_up_wrap", int'(led0), 0);
        chk("mid_up_sat",  int'(led1), 1);
        push = P_BOTH; tick(5);
        chk("both_low_led", int'(led1), 1);
        chk("both_low_lim", int'(lim0), 0);
        rst_n = 1'b0;  tick(1);
        chk("mid_rst_led", int'(led1), 0);
        rst_n = 1'b1;  tick(4);
        chk("post_rst_both", int'(led1), 0);
        push = P_UP;   tick(3);
        chk("no_rpt_wo_press", int'(led1), 0);
        push = P_NONE; tick(1);
        push = P_UP;   tick(1);
        chk("new_press", int'(led1), 1);

        // Button held across reset release counts as a press
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(1);
        chk("held_thru_rst", int'(led1), 1);
        push = P_NONE; tick(1);

        // Randomized runs, mostly single-button holds, occasional reset
        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r < 4)      push = P_UP;
            else if (r < 8) push = P_DN;
            else if (r < 9) push = P_NONE;
            else            push = P_BOTH;
            rst_n = ($urandom_range(0, 40) != 0);
            n = $urandom_range(1, 16);
            repeat (n) begin
                tick(1);
                rst_n = 1'b1;
            end
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
